// File: rtl/xor_descrambler_pkg.sv
// Shared definitions for the PRBS7 XOR scrambler/descrambler path:
// polynomial taps, datapath widths and FSM state encoding.
package xor_descrambler_pkg;

  localparam int unsigned LFSR_W = 7;
  localparam int unsigned SYM_W  = 3;
  localparam int unsigned DROP_W = 8;

  // x^7 + x^6 + 1 expressed as zero-based register taps
  localparam int unsigned TAP_HI = 6;
  localparam int unsigned TAP_LO = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [LFSR_W-1:0] lfsr_t;
  typedef logic [SYM_W-1:0]  sym_t;
  typedef logic [DROP_W-1:0] drop_t;

  function automatic logic lfsr_fb(input lfsr_t s);
    return s[TAP_HI] ^ s[TAP_LO];
  endfunction

  function automatic lfsr_t lfsr_step(input lfsr_t s);
    return {s[LFSR_W-2:0], lfsr_fb(s)};
  endfunction

endpackage

// File: rtl/xor_descrambler_prbs7_step3.sv
// Advances a PRBS7 state by one symbol's worth of steps, returning the
// feedback bits as keystream (k[0] = first step) and the advanced state.
module prbs7_step3
  import xor_descrambler_pkg::*;
(
  input  logic [6:0] s,
  output logic [2:0] k,
  output logic [6:0] s_next
);

  lfsr_t cur;

  always_comb begin
    cur = s;
    k   = '0;
    for (int unsigned i = 0; i < SYM_W; i++) begin
      k[i] = lfsr_fb(cur);
      cur  = lfsr_step(cur);
    end
    s_next = cur;
  end

endmodule

// File: rtl/xor_descrambler.sv
// Receive-side PRBS7 descrambler: reseeds on start-of-frame, strips the
// keystream from each in-frame symbol and counts out-of-frame drops.
module xor_descrambler
  import xor_descrambler_pkg::*;
#(
  parameter logic [6:0] SEED = 7'h7F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_data,
  input  logic       in_sof,
  input  logic       in_eof,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_data,
  output logic       out_sof,
  output logic       out_eof,
  output logic       locked,
  output logic [7:0] drop_cnt
);

  state_t state;
  lfsr_t  lfsr;
  lfsr_t  step_src;
  lfsr_t  step_next;
  sym_t   key;
  logic   accept;
  logic   forward;
  logic   drop;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign forward  = accept && (in_sof || (state == RUN));
  assign drop     = accept && !in_sof && (state == IDLE);
  assign locked   = (state == RUN);

  // A start-of-frame symbol draws its keystream from SEED, not the live state
  assign step_src = in_sof ? SEED : lfsr;

  prbs7_step3 u_step (
    .s      (step_src),
    .k      (key),
    .s_next (step_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= SEED;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      if (forward) begin
        lfsr      <= step_next;
        out_valid <= 1'b1;
        out_data  <= in_data ^ key;
        out_sof   <= in_sof;
        out_eof   <= in_eof;
        state     <= in_eof ? IDLE : RUN;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  seed_nonzero: assert property (@(posedge clk) SEED != '0)
    else $error("xor_descrambler: SEED must be nonzero");

endmodule

// File: doc/xor_descrambler.md
# xor_descrambler

Receive-side counterpart to the team's bitwise XOR scrambling path. It accepts 3-bit scrambled symbols on a valid/ready stream and regenerates the PRBS7 keystream, reseeded at every start-of-frame. Each symbol is XORed with three keystream bits, and the recovered symbol is presented on a registered valid/ready output. It sits between the link receive stage and the frame consumer. It also tracks frame lock and counts symbols that arrive outside a frame.

## Interface
- SEED, 7'h7F, LFSR load value at reset and at every accepted `in_sof`; must be nonzero (zero is illegal, flagged by simulation assertion)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  input symbol valid
- in_ready  out  1  block can accept input symbol
- in_data  in  3  scrambled symbol
- in_sof  in  1  first symbol of frame (qualified by in_valid)
- in_eof  in  1  last symbol of frame (qualified by in_valid)
- out_valid  out  1  recovered symbol valid
- out_ready  in  1  consumer accepts output
- out_data  out  3  descrambled symbol
- out_sof  out  1  in_sof of the symbol on out_data
- out_eof  out  1  in_eof of the symbol on out_data
- locked  out  1  high while state is RUN
- drop_cnt  out  8  saturating count of symbols dropped outside a frame

## Operation
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- Input accept: a symbol is accepted when `in_valid && in_ready`.
- Ready rule: `in_ready = !out_valid || out_ready`. This is combinational from the output register state, giving a one-stage pipeline with full throughput.
- LFSR state `s[6:0]` uses the PRBS7 polynomial x^7+x^6+1. One step is `fb = s[6]^s[5]; s <= {s[5:0],fb}`.
- Each accepted symbol takes three steps: k[0], k[1], k[2] are the fb values of steps 1, 2, 3. Then `out_data = in_data ^ k`.
- On an accepted `in_sof`, the steps start from SEED, not from the current state. After the symbol, s holds SEED advanced 3 steps.
- FSM states:
  - IDLE: accepted symbols without sof are dropped, no output, and `drop_cnt` increments (saturates at 255). An accepted sof symbol is descrambled and output; go to RUN, unless in_eof is also set, in which case stay IDLE.
  - RUN: every accepted symbol is descrambled and output. An accepted eof symbol returns the FSM to IDLE. An accepted sof symbol reseeds and stays RUN (frame restart, no error).
- Dropped symbols are still accepted (in_ready is unaffected) and do not advance the LFSR.
- Output register: on accept-and-forward, `out_data`/`out_sof`/`out_eof` load and `out_valid` is set. When the output is taken with no new symbol forwarded, `out_valid` clears.
- Output stability: out_* stays stable while `out_valid && !out_ready`.

## Timing
- Reset values: out_valid=0, out_data=0, out_sof=0, out_eof=0, locked=0, drop_cnt=0, FSM=IDLE, s=SEED. in_ready=1 immediately after reset.
- Latency: 1 cycle from input accept to out_valid.
- Throughput: 1 symbol/cycle when out_ready is held high.
- Simultaneous events:
  - sof+eof on one symbol: single-symbol frame, output with both flags, FSM ends in IDLE.
  - Accept and output-take in the same cycle: out_valid stays 1 with new data.
- Backpressure: the LFSR and FSM advance only on accept, never on stall cycles.
- Reset mid-frame: all state returns to reset values at once. The in-flight output is discarded. The next symbol must carry sof or it is dropped.
- drop_cnt holds at 8'hFF and is cleared only by reset.

## Structure
- Shared include file: polynomial tap positions (6,5), LFSR width 7, symbol width 3, FSM state encodings (IDLE=1'b0, RUN=1'b1).
- Sub-module `prbs7_step3`: combinational; inputs `s[6:0]`, outputs `k[2:0]` and next state. The scrambler side reuses it.
- Top level holds the FSM, LFSR register, output register and drop counter.

## Test plan
- SEED=7F; sof on 000, then 000, then 101 (eof) with out_ready=1 -> out_data 000, 000, 100; out_sof on the first, out_eof on the third; locked 1 after the first, 0 after the third.
- Three symbols without sof after reset -> no out_valid; drop_cnt=3; locked=0.
- Same frame as the first scenario with out_ready held low for 4 cycles after the first symbol -> in_ready=0 while stalled; out_data holds 000; final outputs identical to the first scenario.
- sof+eof on a single symbol 111 -> out_data 111 (k=000), out_sof=out_eof=1; locked stays 0.
- Mid-frame sof (second symbol carries sof, data 000) -> out_data 000 (reseeded, not 000-then-001 continuation).
- rst_n pulsed low asynchronously while out_valid=1 mid-frame -> out_valid drops immediately; the next non-sof symbol is dropped; 300 drops -> drop_cnt=255.
